// File: rtl/pipe_hazard_unit_if.sv
// Pipeline-side signal bundle for pipe_hazard_unit: hazard inputs from IF/ID/EX/DMEM
// and the stall/flush/status outputs back to the pipeline.
interface pipe_hazard_unit_if #(
  parameter int unsigned REGFILE_ADDR_WIDTH = 5
);
  logic [31:0]                   IF_Instruction;
  logic                          ID_Mem_rd_en;
  logic                          ID_Reg_wr_en;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr;
  logic                          EX_Reg_wr_en;
  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr;
  logic                          EX_PC_Branch;
  logic                          ID_Jump;
  logic                          DMEM_req;
  logic                          DMEM_ready;
  logic                          Stall;
  logic                          IF_ID_Flush;
  logic                          EX_Flush;
  logic                          Mem_timeout;
  logic [1:0]                    Hazard_state;

  modport master (
    output IF_Instruction, ID_Mem_rd_en, ID_Reg_wr_en, ID_Rd_addr,
           EX_Reg_wr_en, EX_Rd_addr, EX_PC_Branch, ID_Jump, DMEM_req, DMEM_ready,
    input  Stall, IF_ID_Flush, EX_Flush, Mem_timeout, Hazard_state
  );

  modport slave (
    input  IF_Instruction, ID_Mem_rd_en, ID_Reg_wr_en, ID_Rd_addr,
           EX_Reg_wr_en, EX_Rd_addr, EX_PC_Branch, ID_Jump, DMEM_req, DMEM_ready,
    output Stall, IF_ID_Flush, EX_Flush, Mem_timeout, Hazard_state
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use stall, DMEM wait stall with sticky timeout, branch/jump flush.
// Optional HAZARD_RAW_STALL_EN adds a one-cycle stall for every RAW hazard (no-forwarding builds).
module pipe_hazard_unit #(
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned LOAD_LATENCY       = 1,
  parameter int unsigned FLUSH_CYCLES       = 2,
  parameter int unsigned MEM_TIMEOUT        = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  pipe_hazard_unit_if.slave hz
);

  localparam int unsigned AW = REGFILE_ADDR_WIDTH;
  localparam logic [2:0]  LAT_M1     = 3'(LOAD_LATENCY - 1);
  localparam logic [2:0]  FLUSH_LOAD = 3'((1 << (FLUSH_CYCLES - 1)) - 1);
  localparam logic [16:0] TMO_LIMIT  = 17'(MEM_TIMEOUT);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  state_e        state_q, state_d, resume_q, resume_d, st, nxt;
  logic [2:0]    ld_cnt_q, ld_cnt_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [2:0]    flush_sr_q, flush_sr_d;
  logic          timeout_q, timeout_d;

  logic          use_rs1, use_rs2;
  logic [AW-1:0] rs1, rs2;
  logic          load_use, raw_hit, dmem_stall, flush_trig, flush_active;
  logic          lu_stall;
  logic [16:0]   cur_wait;
  logic          tmo_hit;
  logic          unused_bits;

  function automatic logic src_match(input logic [AW-1:0] rd, input logic [AW-1:0] r1,
                                     input logic [AW-1:0] r2, input logic u1, input logic u2);
    return (rd != '0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
  endfunction

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (hz.IF_Instruction[6:0])
      OPC_OP, OPC_BRANCH, OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign rs1      = AW'(hz.IF_Instruction[19:15]);
  assign rs2      = AW'(hz.IF_Instruction[24:20]);
  assign load_use = hz.ID_Mem_rd_en && src_match(hz.ID_Rd_addr, rs1, rs2, use_rs1, use_rs2);

`ifdef HAZARD_RAW_STALL_EN
  assign raw_hit = (hz.ID_Reg_wr_en && src_match(hz.ID_Rd_addr, rs1, rs2, use_rs1, use_rs2)) ||
                   (hz.EX_Reg_wr_en && src_match(hz.EX_Rd_addr, rs1, rs2, use_rs1, use_rs2));
  assign unused_bits = ^{hz.IF_Instruction[31:25], hz.IF_Instruction[14:7]};
`else
  assign raw_hit     = 1'b0;
  assign unused_bits = ^{hz.IF_Instruction[31:25], hz.IF_Instruction[14:7],
                         hz.ID_Reg_wr_en, hz.EX_Reg_wr_en, hz.EX_Rd_addr};
`endif

  // While Reset is high every registered contribution is masked so outputs follow inputs only.
  assign st           = Reset ? IDLE : state_q;
  assign dmem_stall   = hz.DMEM_req && !hz.DMEM_ready;
  assign flush_trig   = hz.EX_PC_Branch || hz.ID_Jump;
  assign flush_active = flush_trig || (!Reset && (flush_sr_q != '0));

  always_comb begin
    nxt      = st;
    ld_cnt_d = ld_cnt_q;
    resume_d = resume_q;
    lu_stall = 1'b0;
    case (st)
      IDLE: begin
        if (load_use && !flush_active) begin
          lu_stall = 1'b1;
          if (LOAD_LATENCY > 1) begin
            nxt      = LOAD_STALL;
            ld_cnt_d = LAT_M1;
          end
        end
      end
      LOAD_STALL: begin
        if (flush_active) begin
          nxt      = IDLE;
          ld_cnt_d = '0;
        end else begin
          lu_stall = 1'b1;
          if (!dmem_stall) begin
            ld_cnt_d = ld_cnt_q - 3'd1;
            if (ld_cnt_q == 3'd1) nxt = IDLE;
          end
        end
      end
      MEM_WAIT: begin
        if (flush_active) begin
          nxt      = IDLE;
          ld_cnt_d = '0;
        end else begin
          nxt = resume_q;
        end
      end
      default: nxt = IDLE;
    endcase
    // A DMEM wait parks the load-use continuation in resume_d with its counter frozen.
    if (dmem_stall) begin
      resume_d = nxt;
      state_d  = MEM_WAIT;
    end else begin
      state_d  = nxt;
    end
  end

  assign cur_wait   = {1'b0, wait_cnt_q} + 17'd1;
  assign tmo_hit    = dmem_stall && (cur_wait >= TMO_LIMIT);
  assign wait_cnt_d = !dmem_stall ? '0 : (tmo_hit ? TMO_LIMIT[15:0] : cur_wait[15:0]);
  assign timeout_d  = timeout_q || tmo_hit;

  always_comb begin
    if (flush_trig)      flush_sr_d = FLUSH_LOAD;
    else if (dmem_stall) flush_sr_d = flush_sr_q;
    else                 flush_sr_d = flush_sr_q >> 1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      resume_q   <= IDLE;
      ld_cnt_q   <= '0;
      wait_cnt_q <= '0;
      flush_sr_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      ld_cnt_q   <= ld_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      flush_sr_q <= flush_sr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hz.Stall        = dmem_stall || lu_stall || (raw_hit && !flush_active);
  assign hz.IF_ID_Flush  = flush_active;
  assign hz.EX_Flush     = hz.EX_PC_Branch;
  assign hz.Mem_timeout  = !Reset && (timeout_q || tmo_hit);
  assign hz.Hazard_state = st;

endmodule
